prize_grid_manager: RTL and testbench

//  Parametrised tile-grid prize store for the Bumpy game: holds one TYPE_W-bit prize code per grid cell.

---
 rtl/prize_grid_manager.sv | 191 +++++++++++++++++++
 tb/tb_prize_grid_manager.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prize_grid_manager.sv
// rtl/prize_grid_manager.sv - tile-grid prize store with map loader, pixel lookup and collection
//
// Holds one TYPE_W-bit prize code per grid cell (code 0 = FREE). A built-in
// level map is copied into the store one cell per clock. The store also feeds
// a registered per-pixel lookup to the drawing path. Bumpy collecting a prize
// clears its cell and reports the collected type and points.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pixelX, pixelY        current VGA pixel
//   bumpy_x, bumpy_y      Bumpy top-left position
//   prize_collision       collision level from the collision block
//   load_req, map_sel     one-cycle reload request and the map it selects
//   prize_type            prize code at the pixel's cell (0 outside grid), 1-cycle latency
//   tileTopLeftX/Y        origin of the pixel's tile, 1-cycle latency
//   collect_valid         one-cycle pulse per collected prize
//   collect_type/points   last collected prize and its points (held)
//   prizes_left           non-FREE cells remaining
//   level_cleared, busy   FSM in CLEARED / LOAD
module prize_grid_manager #(
  parameter int NUM_OF_ROWS = 7,
  parameter int NUM_OF_COLS = 10,
  parameter int TILE_SHIFT  = 6,
  parameter int TYPE_W      = 3,
  parameter int CNT_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       pixelX,
  input  logic [10:0]       pixelY,
  input  logic [10:0]       bumpy_x,
  input  logic [10:0]       bumpy_y,
  input  logic              prize_collision,
  input  logic              load_req,
  input  logic              map_sel,
  output logic [TYPE_W-1:0] prize_type,
  output logic [10:0]       tileTopLeftX,
  output logic [10:0]       tileTopLeftY,
  output logic              collect_valid,
  output logic [TYPE_W-1:0] collect_type,
  output logic [7:0]        collect_points,
  output logic [CNT_W-1:0]  prizes_left,
  output logic              level_cleared,
  output logic              busy
);

  localparam int          CELLS     = NUM_OF_ROWS * NUM_OF_COLS;
  localparam int          IDX_W     = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [10:0] ROWS_L    = 11'(NUM_OF_ROWS);
  localparam logic [10:0] COLS_L    = 11'(NUM_OF_COLS);
  localparam logic [10:0] TILE_MASK = ~11'((1 << TILE_SHIFT) - 1);

  typedef enum logic [1:0] {LOAD, PLAY, CLEARED} state_t;

  state_t state, state_nxt;

  logic [TYPE_W-1:0] store [CELLS];
  logic              map_q;
  logic [10:0]       load_row, load_col;
  logic [CNT_W-1:0]  load_count, load_count_fin;
  logic              coll_d1;

  function automatic logic [TYPE_W-1:0] rom_cell(input logic sel, input logic [10:0] r,
                                                 input logic [10:0] c);
    logic [TYPE_W-1:0] t;
    t = '0;
    if (!sel) begin
      if ((r == 11'd0 && c == 11'd1) || (r == 11'd0 && c == 11'd8) ||
          (r == 11'd1 && c == 11'd5) || (r == 11'd3 && c == 11'd0) ||
          (r == 11'd3 && c == 11'd3) || (r == 11'd3 && c == 11'd9) ||
          (r == 11'd4 && c == 11'd4) || (r == 11'd4 && c == 11'd6) ||
          (r == 11'd6 && c == 11'd2))
        t = TYPE_W'(1);
    end else begin
      if (r == 11'd0 && c == 11'd0) t = TYPE_W'(1);
      if (r == 11'd0 && c == 11'd9) t = TYPE_W'(2);
      if (r == 11'd2 && c == 11'd4) t = TYPE_W'(3);
      if (r == 11'd5 && c == 11'd5) t = TYPE_W'(2);
      if (r == 11'd6 && c == 11'd9) t = TYPE_W'(1);
    end
    return t;
  endfunction

  function automatic logic [7:0] points_of(input logic [TYPE_W-1:0] t);
    case (t)
      TYPE_W'(1): points_of = 8'd10;
      TYPE_W'(2): points_of = 8'd25;
      TYPE_W'(3): points_of = 8'd50;
      default:    points_of = 8'd5;
    endcase
  endfunction

  // Grid coordinates; bounds are checked before the index is formed so an
  // out-of-grid position never touches the store.
  logic [10:0]       pix_row, pix_col, bmp_row, bmp_col;
  logic              pix_in_grid, bmp_in_grid;
  logic [IDX_W-1:0]  pix_idx, bmp_idx, load_idx;
  logic [TYPE_W-1:0] rom_val, bmp_cell;
  logic              coll_event, collect_hit, load_last;

  assign pix_row     = pixelY >> TILE_SHIFT;
  assign pix_col     = pixelX >> TILE_SHIFT;
  assign bmp_row     = bumpy_y >> TILE_SHIFT;
  assign bmp_col     = bumpy_x >> TILE_SHIFT;
  assign pix_in_grid = (pix_row < ROWS_L) && (pix_col < COLS_L);
  assign bmp_in_grid = (bmp_row < ROWS_L) && (bmp_col < COLS_L);
  assign pix_idx     = pix_in_grid ? IDX_W'(pix_row * COLS_L + pix_col) : '0;
  assign bmp_idx     = bmp_in_grid ? IDX_W'(bmp_row * COLS_L + bmp_col) : '0;
  assign load_idx    = IDX_W'(load_row * COLS_L + load_col);
  assign bmp_cell    = bmp_in_grid ? store[bmp_idx] : '0;

  assign rom_val        = rom_cell(map_q, load_row, load_col);
  assign load_count_fin = load_count + ((rom_val != '0) ? CNT_W'(1) : CNT_W'(0));
  assign load_last      = (state == LOAD) && (load_row == ROWS_L - 11'd1) &&
                          (load_col == COLS_L - 11'd1);
  assign coll_event     = prize_collision & ~coll_d1;
  // A reload request takes priority and swallows a simultaneous collision.
  assign collect_hit    = (state == PLAY) && coll_event && !load_req && (bmp_cell != '0);

  assign busy          = (state == LOAD);
  assign level_cleared = (state == CLEARED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        LOAD:    if (load_last) state_nxt = (load_count_fin == '0) ? CLEARED : PLAY;
        PLAY:    if (collect_hit && prizes_left == CNT_W'(1)) state_nxt = CLEARED;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) store[i] <= '0;
      map_q          <= 1'b0;
      load_row       <= '0;
      load_col       <= '0;
      load_count     <= '0;
      coll_d1        <= 1'b0;
      prize_type     <= '0;
      tileTopLeftX   <= '0;
      tileTopLeftY   <= '0;
      collect_valid  <= 1'b0;
      collect_type   <= '0;
      collect_points <= '0;
      prizes_left    <= '0;
    end else begin
      coll_d1       <= prize_collision;
      collect_valid <= 1'b0;
      // Nonblocking read: a cell written this clock still returns its old value.
      prize_type    <= pix_in_grid ? store[pix_idx] : '0;
      tileTopLeftX  <= pixelX & TILE_MASK;
      tileTopLeftY  <= pixelY & TILE_MASK;
      if (load_req) begin
        map_q      <= map_sel;
        load_row   <= '0;
        load_col   <= '0;
        load_count <= '0;
      end else if (state == LOAD) begin
        store[load_idx] <= rom_val;
        if (load_last) begin
          prizes_left <= load_count_fin;
        end else begin
          load_count <= load_count_fin;
          if (load_col == COLS_L - 11'd1) begin
            load_col <= '0;
            load_row <= load_row + 11'd1;
          end else begin
            load_col <= load_col + 11'd1;
          end
        end
      end else if (collect_hit) begin
        store[bmp_idx] <= '0;
        collect_valid  <= 1'b1;
        collect_type   <= bmp_cell;
        collect_points <= points_of(bmp_cell);
        prizes_left    <= prizes_left - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prize_grid_manager.sv
// tb/tb_prize_grid_manager.sv - scoreboard bench for prize_grid_manager
module tb_prize_grid_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixelX, pixelY, bumpy_x, bumpy_y;
  logic        prize_collision, load_req, map_sel;
  logic [2:0]  prize_type;
  logic [10:0] tileTopLeftX, tileTopLeftY;
  logic        collect_valid;
  logic [2:0]  collect_type;
  logic [7:0]  collect_points;
  logic [6:0]  prizes_left;
  logic        level_cleared, busy;

  prize_grid_manager dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .bumpy_x(bumpy_x), .bumpy_y(bumpy_y), .prize_collision(prize_collision),
    .load_req(load_req), .map_sel(map_sel), .prize_type(prize_type),
    .tileTopLeftX(tileTopLeftX), .tileTopLeftY(tileTopLeftY),
    .collect_valid(collect_valid), .collect_type(collect_type),
    .collect_points(collect_points), .prizes_left(prizes_left),
    .level_cleared(level_cleared), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int t;
    int pts;
    int left;
    int clr;
  } collect_t;

  collect_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int n;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every collect pulse must match the oldest expected collection.
  always @(negedge clk) begin
    if (!reset && collect_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_collect_pulse", 1, 0);
      end else begin
        collect_t e;
        e = exp_q.pop_front();
        check("collect_type", int'(collect_type), e.t);
        check("collect_points", int'(collect_points), e.pts);
        check("collect_prizes_left", int'(prizes_left), e.left);
        check("collect_level_cleared", int'(level_cleared), e.clr);
      end
    end
  end

  task automatic expect_collect(input int t, input int pts, input int left, input int clr);
    collect_t e;
    e.t = t; e.pts = pts; e.left = left; e.clr = clr;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (busy && cycles < 300);
  endtask

  task automatic lookup(input string name, input int x, input int y, input int t,
                        input int tx, input int ty);
    @(posedge clk); #1;
    pixelX = 11'(x); pixelY = 11'(y);
    @(posedge clk); #1;
    check({name, "_type"}, int'(prize_type), t);
    check({name, "_tileX"}, int'(tileTopLeftX), tx);
    check({name, "_tileY"}, int'(tileTopLeftY), ty);
  endtask

  task automatic collide(input int x, input int y, input int hold);
    @(posedge clk); #1;
    bumpy_x = 11'(x); bumpy_y = 11'(y);
    prize_collision = 1'b1;
    repeat (hold) @(posedge clk);
    #1 prize_collision = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic m);
    @(posedge clk); #1;
    load_req = 1'b1; map_sel = m;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pixelX = '0; pixelY = '0; bumpy_x = '0; bumpy_y = '0;
    prize_collision = 1'b0; load_req = 1'b0; map_sel = 1'b0;
    #3;
    check("reset_busy", int'(busy), 1);
    check("reset_prizes_left", int'(prizes_left), 0);
    check("reset_level_cleared", int'(level_cleared), 0);
    check("reset_collect_valid", int'(collect_valid), 0);
    check("reset_prize_type", int'(prize_type), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1. auto-load map0
    wait_idle(n);
    check("load0_cycles", n, 70);
    check("load0_prizes_left", int'(prizes_left), 9);
    check("load0_level_cleared", int'(level_cleared), 0);
    lookup("pix_100_10", 100, 10, 1, 64, 0);
    lookup("pix_0_0", 0, 0, 0, 0, 0);
    lookup("pix_out_x", 700, 10, 0, 640, 0);
    lookup("pix_out_y", 200, 460, 0, 192, 448);
    lookup("pix_4_6", 400, 300, 1, 384, 256);

    // 2. held collision gives exactly one collect
    expect_collect(1, 10, 8, 0);
    collide(70, 5, 10);
    check("after_hold_left", int'(prizes_left), 8);
    lookup("cell_0_1_cleared", 70, 5, 0, 64, 0);

    // 3. FREE cell and out-of-grid column are ignored
    collide(0, 0, 2);
    collide(700, 5, 2);
    check("ignored_left", int'(prizes_left), 8);

    // 4. map1, collect everything
    pulse_load(1'b1);
    wait_idle(n);
    check("load1_cycles", n, 70);
    check("load1_prizes_left", int'(prizes_left), 5);
    expect_collect(1, 10, 4, 0); collide(5, 5, 1);
    expect_collect(2, 25, 3, 0); collide(580, 10, 1);
    expect_collect(3, 50, 2, 0); collide(260, 130, 1);
    expect_collect(2, 25, 1, 0); collide(330, 330, 1);
    expect_collect(1, 10, 0, 1); collide(580, 390, 1);
    check("cleared_flag", int'(level_cleared), 1);
    check("cleared_left", int'(prizes_left), 0);
    check("cleared_busy", int'(busy), 0);

    // 5. reload interrupted mid-LOAD, then load_req beats a collision edge
    pulse_load(1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("midload_busy", int'(busy), 1);
    pulse_load(1'b1);
    wait_idle(n);
    check("restart_cycles", n, 70);
    check("restart_left", int'(prizes_left), 5);
    @(posedge clk); #1;
    bumpy_x = 11'd5; bumpy_y = 11'd5;
    prize_collision = 1'b1; load_req = 1'b1; map_sel = 1'b0;
    @(posedge clk); #1;
    load_req = 1'b0; prize_collision = 1'b0;
    wait_idle(n);
    check("coinc_cycles", n, 70);
    check("coinc_left", int'(prizes_left), 9);
    lookup("coinc_map0", 100, 10, 1, 64, 0);

    // 6. async reset mid-PLAY
    expect_collect(1, 10, 8, 0);
    collide(70, 5, 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("areset_busy", int'(busy), 1);
    check("areset_left", int'(prizes_left), 0);
    check("areset_type", int'(prize_type), 0);
    check("areset_tileX", int'(tileTopLeftX), 0);
    check("areset_ctype", int'(collect_type), 0);
    check("areset_points", int'(collect_points), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_idle(n);
    check("reload_cycles", n, 70);
    check("reload_left", int'(prizes_left), 9);
    lookup("reload_cell_0_1", 70, 5, 1, 64, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
